// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding, the default reset PC, the NOP word used for faulted fetches
// and the sequential PC increment.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/fetch_obuf.sv
// Output holding register between the fetch FSM and ID.
// load  : capture pc / inst / adel, compute pc+4 (32-bit wrap), set valid
// clear : drop valid and adel, keep the last pc / inst visible
// else  : hold
// Ports: clk, resetn, load, clear, ld_pc, ld_inst, ld_adel ->
//        valid, pc, pc4, inst, adel
module fetch_obuf
   import fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] ld_pc,
   input  logic [31:0] ld_inst,
   input  logic        ld_adel,
   output logic        valid,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] inst,
   output logic        adel
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid <= 1'b0;
         pc    <= '0;
         pc4   <= '0;
         inst  <= '0;
         adel  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= ld_pc;
         pc4   <= ld_pc + PC_STEP;
         inst  <= ld_inst;
         adel  <= ld_adel;
      end else if (clear) begin
         valid <= 1'b0;
         adel  <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller driving an SRAM-like instruction port with
// at most one request in flight, redirect/flush handling and an output
// holding register towards ID.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   flush_valid/flush_pc             exception/ERET redirect (wins)
//   redirect_valid/redirect_pc       branch/jump target from ID
//   id_allowin                       ID accepts the held instruction
//   inst_req/inst_addr               request to instruction memory
//   inst_addr_ok/data_ok/rdata       memory handshake and data
//   if_valid/if_pc/if_pc4/if_inst    fetched instruction to ID
//   if_adel                          fetch address error
// Build option: FETCH_ADEL_CHECK_EN enables the PC alignment check; without
// it if_adel is constant 0.
//
// state | meaning
// REQ   | request presented (inst_req=1) until addr_ok; inst_req=0 here
//       | means nothing issued yet (post-reset or misaligned PC)
// WAIT  | request accepted, waiting for data_ok
// HOLD  | instruction valid to ID, waiting for id_allowin
// DROP  | stale response outstanding, jump to pending target on data_ok
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush_valid,
   input  logic [31:0] flush_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_allowin,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic [31:0] if_inst,
   output logic        if_adel
);

   fetch_state_t state, nxt_state;
   logic [31:0]  pc, nxt_pc;
   logic         pend_valid, pend_flush, nxt_pend_valid, nxt_pend_flush;
   logic [31:0]  pend_pc, nxt_pend_pc;
   logic         mrg_valid, mrg_flush;
   logic [31:0]  mrg_pc;
   logic         pc_bad, nxt_bad;
   logic         ob_load, ob_clear, ob_adel;
   logic [31:0]  ob_inst;

   assign inst_addr = pc;

`ifdef FETCH_ADEL_CHECK_EN
   assign pc_bad  = |pc[1:0];
   assign nxt_bad = |nxt_pc[1:0];
`else
   assign pc_bad  = 1'b0;
   assign nxt_bad = 1'b0;
`endif

   // Fold this cycle's flush/redirect into the pending target. A flush
   // always wins; a redirect may not displace a pending flush.
   always_comb begin
      mrg_valid = pend_valid;
      mrg_flush = pend_flush;
      mrg_pc    = pend_pc;
      if (flush_valid) begin
         mrg_valid = 1'b1;
         mrg_flush = 1'b1;
         mrg_pc    = flush_pc;
      end else if (redirect_valid && !(pend_valid && pend_flush)) begin
         mrg_valid = 1'b1;
         mrg_flush = 1'b0;
         mrg_pc    = redirect_pc;
      end
   end

   always_comb begin
      nxt_state      = state;
      nxt_pc         = pc;
      nxt_pend_valid = mrg_valid;
      nxt_pend_flush = mrg_flush;
      nxt_pend_pc    = mrg_pc;
      ob_load        = 1'b0;
      ob_clear       = 1'b0;
      ob_adel        = 1'b0;
      ob_inst        = inst_rdata;
      case (state)
         ST_REQ: begin
            if (!inst_req) begin
               // nothing issued, so a new target can be taken directly
               if (mrg_valid) begin
                  nxt_pc         = mrg_pc;
                  nxt_pend_valid = 1'b0;
                  nxt_pend_flush = 1'b0;
               end else if (pc_bad) begin
                  nxt_state = ST_HOLD;
                  ob_load   = 1'b1;
                  ob_inst   = NOP_INST;
                  ob_adel   = 1'b1;
               end
            end else if (inst_addr_ok) begin
               nxt_state = mrg_valid ? ST_DROP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (inst_data_ok) begin
               if (mrg_valid) begin
                  nxt_state      = ST_REQ;
                  nxt_pc         = mrg_pc;
                  nxt_pend_valid = 1'b0;
                  nxt_pend_flush = 1'b0;
               end else begin
                  nxt_state = ST_HOLD;
                  ob_load   = 1'b1;
               end
            end else if (mrg_valid) begin
               nxt_state = ST_DROP;
            end
         end
         ST_HOLD: begin
            if (mrg_valid) begin
               nxt_state      = ST_REQ;
               nxt_pc         = mrg_pc;
               nxt_pend_valid = 1'b0;
               nxt_pend_flush = 1'b0;
               ob_clear       = 1'b1;
            end else if (id_allowin) begin
               nxt_state = ST_REQ;
               nxt_pc    = if_pc4;
               ob_clear  = 1'b1;
            end
         end
         ST_DROP: begin
            if (inst_data_ok) begin
               nxt_state      = ST_REQ;
               nxt_pc         = mrg_pc;
               nxt_pend_valid = 1'b0;
               nxt_pend_flush = 1'b0;
            end
         end
         default: nxt_state = ST_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_REQ;
         pc         <= RESET_PC;
         inst_req   <= 1'b0;
         pend_valid <= 1'b0;
         pend_flush <= 1'b0;
         pend_pc    <= '0;
      end else begin
         state      <= nxt_state;
         pc         <= nxt_pc;
         inst_req   <= (nxt_state == ST_REQ) && !nxt_bad;
         pend_valid <= nxt_pend_valid;
         pend_flush <= nxt_pend_flush;
         pend_pc    <= nxt_pend_pc;
      end
   end

   fetch_obuf u_obuf (
      .clk     (clk),
      .resetn  (resetn),
      .load    (ob_load),
      .clear   (ob_clear),
      .ld_pc   (pc),
      .ld_inst (ob_inst),
      .ld_adel (ob_adel),
      .valid   (if_valid),
      .pc      (if_pc),
      .pc4     (if_pc4),
      .inst    (if_inst),
      .adel    (if_adel)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   localparam logic [31:0] B = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush_valid, redirect_valid, id_allowin;
   logic [31:0] flush_pc, redirect_pc;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        if_valid, if_adel;
   logic [31:0] if_pc, if_pc4, if_inst;

   int n_cmp = 0;
   int n_err = 0;

   logic        mem_busy = 1'b0;
   logic [31:0] mem_addr = '0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk            (clk),
      .resetn         (resetn),
      .flush_valid    (flush_valid),
      .flush_pc       (flush_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_allowin     (id_allowin),
      .inst_req       (inst_req),
      .inst_addr      (inst_addr),
      .inst_addr_ok   (inst_addr_ok),
      .inst_data_ok   (inst_data_ok),
      .inst_rdata     (inst_rdata),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pc4         (if_pc4),
      .if_inst        (if_inst),
      .if_adel        (if_adel)
   );

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      flush_valid = 1'b0; flush_pc = '0;
      redirect_valid = 1'b0; redirect_pc = '0;
      id_allowin = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
   endtask

   // One clock: record the handshake presented this cycle, advance, settle.
   task automatic tick();
      logic acc, ret;
      logic [31:0] a;
      acc = inst_req && inst_addr_ok;
      ret = inst_data_ok;
      a   = inst_addr;
      @(posedge clk);
      #1;
      if (ret) mem_busy = 1'b0;
      if (acc) begin
         mem_busy = 1'b1;
         mem_addr = a;
      end
   endtask

   typedef struct {
      logic        aok, dok, allow, rv, fv;
      logic [31:0] rpc, fpc, rdata;
      logic        e_req, e_valid;
      logic [31:0] e_addr, e_pc, e_inst;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic aok, input logic dok, input logic allow,
                               input logic rv, input logic [31:0] rpc,
                               input logic fv, input logic [31:0] fpc,
                               input logic [31:0] rdata,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc,
                               input logic [31:0] e_inst);
      vec_t v;
      v.aok = aok; v.dok = dok; v.allow = allow; v.rv = rv; v.fv = fv;
      v.rpc = rpc; v.fpc = fpc; v.rdata = rdata;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_pc = e_pc; v.e_inst = e_inst;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp_next, fpc_r, rpc_r, prev_addr;
      logic        blk, prev_hold, allow, fl, rd;
      int          idle, n_cons;

      drive_idle();
      resetn = 1'b0;

      // rows: aok dok allow rv rpc fv fpc rdata | req addr valid pc inst
      vt.push_back(mk(0,0,0,0,0,0,0,0,            0,B,0,0,0));
      vt.push_back(mk(1,0,0,0,0,0,0,0,            1,B,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,32'h2408_0001, 0,0,0,0,0));
      for (int k = 0; k < 5; k++)
         vt.push_back(mk(0,0,0,0,0,0,0,0,         0,0,1,B,32'h2408_0001));
      vt.push_back(mk(0,0,1,0,0,0,0,0,            0,0,1,B,32'h2408_0001));
      vt.push_back(mk(1,0,0,0,0,0,0,0,            1,B+4,0,0,0));
      vt.push_back(mk(0,0,0,1,B+32'h100,0,0,0,    0,0,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,32'hDEAD_BEEF, 0,0,0,0,0));
      vt.push_back(mk(1,0,0,0,0,0,0,0,            1,B+32'h100,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,32'h0000_000C, 0,0,0,0,0));
      vt.push_back(mk(0,0,0,1,B+32'h100,1,B+32'h380,0, 0,0,1,B+32'h100,32'hC));
      vt.push_back(mk(1,0,0,0,0,0,0,0,            1,B+32'h380,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,32'h42,       0,0,0,0,0));
      vt.push_back(mk(0,0,1,1,B+32'h200,0,0,0,    0,0,1,B+32'h380,32'h42));
      vt.push_back(mk(0,0,0,0,0,0,0,0,            1,B+32'h200,0,0,0));
      vt.push_back(mk(0,0,0,1,B+32'h300,0,0,0,    1,B+32'h200,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,            1,B+32'h200,0,0,0));
      vt.push_back(mk(1,0,0,0,0,0,0,0,            1,B+32'h200,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,            0,0,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,32'h99,       0,0,0,0,0));
      vt.push_back(mk(1,0,0,0,0,0,0,0,            1,B+32'h300,0,0,0));
      vt.push_back(mk(0,1,0,0,0,0,0,32'h77,       0,0,0,0,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0,            0,0,1,B+32'h300,32'h77));

      repeat (3) @(posedge clk);
      #1;
      chk1 ("rst_req",   inst_req, 1'b0);
      chk1 ("rst_valid", if_valid, 1'b0);
      chk1 ("rst_adel",  if_adel,  1'b0);
      chk32("rst_pc",    if_pc,    32'h0);
      chk32("rst_pc4",   if_pc4,   32'h0);
      chk32("rst_inst",  if_inst,  32'h0);
      chk32("rst_addr",  inst_addr, B);
      resetn = 1'b1;

      foreach (vt[i]) begin
         chk1($sformatf("row%0d_req", i), inst_req, vt[i].e_req);
         if (vt[i].e_req) chk32($sformatf("row%0d_addr", i), inst_addr, vt[i].e_addr);
         chk1($sformatf("row%0d_valid", i), if_valid, vt[i].e_valid);
         chk1($sformatf("row%0d_adel", i), if_adel, 1'b0);
         if (vt[i].e_valid) begin
            chk32($sformatf("row%0d_pc", i),   if_pc,   vt[i].e_pc);
            chk32($sformatf("row%0d_pc4", i),  if_pc4,  vt[i].e_pc + 32'd4);
            chk32($sformatf("row%0d_inst", i), if_inst, vt[i].e_inst);
         end
         inst_addr_ok   = vt[i].aok;
         inst_data_ok   = vt[i].dok;
         inst_rdata     = vt[i].rdata;
         id_allowin     = vt[i].allow;
         redirect_valid = vt[i].rv;
         redirect_pc    = vt[i].rpc;
         flush_valid    = vt[i].fv;
         flush_pc       = vt[i].fpc;
         tick();
      end
      drive_idle();

`ifdef FETCH_ADEL_CHECK_EN
      // misaligned redirect target: no request, straight to an error slot
      redirect_valid = 1'b1; redirect_pc = B + 32'h102;
      tick();
      drive_idle();
      chk1("adel_noreq0", inst_req, 1'b0);
      tick();
      chk1("adel_noreq1", inst_req, 1'b0);
      tick();
      chk1 ("adel_noreq2", inst_req, 1'b0);
      chk1 ("adel_valid",  if_valid, 1'b1);
      chk1 ("adel_flag",   if_adel,  1'b1);
      chk32("adel_inst",   if_inst,  32'h0);
      chk32("adel_pc",     if_pc,    B + 32'h102);
`endif

      // PC wraps past 0xFFFF_FFFC
      flush_valid = 1'b1; flush_pc = 32'hFFFF_FFFC;
      tick();
      drive_idle();
      chk1 ("wrap_req",  inst_req,  1'b1);
      chk32("wrap_addr", inst_addr, 32'hFFFF_FFFC);
      inst_addr_ok = 1'b1;
      tick();
      drive_idle();
      inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
      tick();
      drive_idle();
      chk1 ("wrap_valid", if_valid, 1'b1);
      chk1 ("wrap_adel",  if_adel,  1'b0);
      chk32("wrap_pc4",   if_pc4,   32'h0);
      id_allowin = 1'b1;
      tick();
      drive_idle();
      chk32("wrap_next_addr", inst_addr, 32'h0);

      // reset while a request is outstanding
      inst_addr_ok = 1'b1;
      tick();
      drive_idle();
      resetn = 1'b0;
      #2;
      chk1 ("midrst_req",   inst_req,  1'b0);
      chk1 ("midrst_valid", if_valid,  1'b0);
      chk32("midrst_addr",  inst_addr, B);
      chk32("midrst_pc",    if_pc,     32'h0);
      @(posedge clk);
      #1;
      resetn   = 1'b1;
      mem_busy = 1'b0;
      chk1("midrst_rel_req", inst_req, 1'b0);
      tick();
      chk1 ("midrst_first_req",  inst_req,  1'b1);
      chk32("midrst_first_addr", inst_addr, B);

      // randomized traffic against a stream model: the delivered PCs must
      // follow pc+4 except where a flush/redirect names the next one
      exp_next  = B;
      blk       = 1'b0;
      prev_hold = 1'b0;
      prev_addr = '0;
      idle      = 0;
      n_cons    = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (prev_hold) begin
            chk1 ("rnd_req_held",  inst_req,  1'b1);
            chk32("rnd_addr_held", inst_addr, prev_addr);
         end
         if (inst_req) chk1("rnd_one_outstanding", mem_busy, 1'b0);

         allow = 1'($urandom % 2);
         fl    = ($urandom_range(39, 0) == 0);
         rd    = !blk && ($urandom_range(14, 0) == 0);
         fpc_r = 32'($urandom) & 32'hFFFF_FFFC;
         rpc_r = 32'($urandom) & 32'hFFFF_FFFC;

         if (if_valid && allow) begin
            chk32("rnd_pc",   if_pc,   exp_next);
            chk32("rnd_pc4",  if_pc4,  exp_next + 32'd4);
            chk32("rnd_inst", if_inst, ~exp_next);
            chk1 ("rnd_adel", if_adel, 1'b0);
            exp_next = exp_next + 32'd4;
            blk      = 1'b0;
            idle     = 0;
            n_cons++;
         end
         if (fl) begin
            exp_next = fpc_r;
            blk      = 1'b1;
         end else if (rd) begin
            exp_next = rpc_r;
            blk      = 1'b1;
         end

         id_allowin     = allow;
         flush_valid    = fl;
         flush_pc       = fpc_r;
         redirect_valid = rd;
         redirect_pc    = rpc_r;
         inst_addr_ok   = inst_req && ($urandom % 3 != 0);
         inst_data_ok   = mem_busy && ($urandom % 3 != 0);
         inst_rdata     = inst_data_ok ? ~mem_addr : 32'($urandom);
         prev_hold      = inst_req && !inst_addr_ok;
         prev_addr      = inst_addr;
         tick();
         idle++;
         if (idle > 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL rnd_liveness: no delivery for %0d cycles, required <= 200", idle);
            break;
         end
      end
      drive_idle();
      chk1("rnd_enough_deliveries", n_cons > 50, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, SHALL be the PC fetched first after reset.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 resetn  input  1  SHALL be asynchronous, active-low reset.
REQ-004 flush_valid, flush_pc  input  1, 32  exception/ERET redirect.
REQ-005 redirect_valid, redirect_pc  input  1, 32  branch/jump target resolved in ID.
REQ-006 id_allowin  input  1  ID can accept an instruction this cycle.
REQ-007 inst_req, inst_addr  output  1, 32  SRAM-like request and word address.
REQ-008 inst_addr_ok, inst_data_ok, inst_rdata  input  1, 1, 32  request accepted; data returned; instruction word.
REQ-009 if_valid, if_pc, if_pc4, if_inst  output  1, 32, 32, 32  fetched instruction to ID.
REQ-010 if_adel  output  1  fetch address error flag.

Function
REQ-011 States SHALL be REQ (inst_req=1, waiting addr_ok), WAIT (waiting data_ok), HOLD (output valid, waiting id_allowin), DROP (stale response outstanding).
REQ-012 At most one request SHALL be outstanding.
REQ-013 In REQ, inst_req and inst_addr SHALL be held stable until inst_addr_ok.
REQ-014 REQ + inst_addr_ok -> WAIT, or -> DROP if a redirect/flush is pending or arrives that cycle.
REQ-015 WAIT + inst_data_ok -> HOLD: if_inst<=inst_rdata, if_pc<=fetch PC, if_pc4<=fetch PC+4, if_valid=1 from the next cycle.
REQ-016 HOLD + id_allowin -> REQ with PC = if_pc+4 (32-bit wrap, no carry out), if_valid=0 from the next cycle.
REQ-017 DROP + inst_data_ok -> REQ at the pending target; inst_rdata discarded; if_valid stays 0.
REQ-018 Redirect in REQ before addr_ok SHALL be latched as pending and the current address kept.
REQ-019 Redirect in WAIT -> DROP. Redirect in HOLD -> REQ at the target, clearing if_valid.
REQ-020 flush_valid SHALL take priority over redirect_valid in the same cycle; a later flush overwrites any pending target.
REQ-021 redirect_valid and id_allowin in the same HOLD cycle: the instruction is consumed and the next PC is redirect_pc.
REQ-022 Best-case latency: addr_ok at cycle N, data_ok at N+1, if_valid at N+2.

Reset
REQ-023 While resetn=0: state=REQ, PC=RESET_PC, inst_req=0, if_valid=0, if_adel=0, if_pc/if_pc4/if_inst=0, no pending target.
REQ-024 First cycle after release SHALL assert inst_req with inst_addr=RESET_PC.
REQ-025 Reset mid-transaction SHALL abandon it; the memory is reset on the same resetn.

Configuration
REQ-026 Macro FETCH_ADEL_CHECK_EN defined: a PC with pc[1:0]!=0 SHALL issue no request and go straight to HOLD with if_inst=0 and if_adel=1.
REQ-027 Macro absent: no alignment check; if_adel SHALL be tied to 0.

Structure
REQ-028 Shared package SHALL hold the state encoding, RESET_PC default, and the 32'h0 NOP constant.
REQ-029 Output holding register SHALL be sub-module fetch_obuf: load, clear, hold.

Verification
REQ-030 Reset release, addr_ok/data_ok immediate, rdata=32'h2408_0001 -> inst_addr=BFC0_0000, if_valid at cycle 3, if_pc4=BFC0_0004.
REQ-031 id_allowin=0 for 5 cycles in HOLD -> if_inst/if_pc stable and no new inst_req; release -> next inst_addr=BFC0_0004.
REQ-032 redirect_pc=BFC0_0100 in WAIT -> old data dropped and if_valid=0; next inst_addr=BFC0_0100.
REQ-033 flush_pc=BFC0_0380 and redirect_pc=BFC0_0100 in the same cycle -> next fetch at BFC0_0380.
REQ-034 addr_ok delayed 3 cycles with redirect in the 2nd -> inst_addr stable until accepted, then DROP, then fetch at the target.
REQ-035 FETCH_ADEL_CHECK_EN set, redirect_pc=BFC0_0102 -> no inst_req, if_valid=1, if_adel=1, if_inst=0.
